// File: rtl/pin_array_arb_pkg.sv
// Shared types and defaults for the pin array arbiter.
package pin_array_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_GAP
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pin_array_arb_if.sv
// Requester-side bundle of the pin array arbiter.
interface pin_array_arb_if
    import pin_array_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic [NREQ-1:0] vin;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   owner;
    logic            busy;
    logic            vout;

    modport master (
        output req, rel, vin,
        input  gnt, owner, busy, vout
    );

    modport slave (
        input  req, rel, vin,
        output gnt, owner, busy, vout
    );

endinterface

// File: rtl/pin_array_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_pick
    import pin_array_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        int unsigned slot;
        slot   = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            slot = (32'(ptr) + k) % NREQ;
            if (!valid && req[slot]) begin
                valid  = 1'b1;
                winner = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/pin_array_arb.sv
// Round-robin arbiter for one shared output pin with hold limit and a
// one-cycle break-before-make gap between owners.
module pin_array_arb
    import pin_array_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pin_array_arb_if.slave bus
);

    localparam int IW = idx_w(NREQ);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    own_idx;
    logic [CNT_W-1:0] hold;
    logic [NREQ-1:0]  gnt_q;
    logic             busy_q;
    logic             vout_q;

    logic [IW-1:0]    winner;
    logic             win_valid;
    logic             exit_own;
    logic [IW-1:0]    ptr_next;
    logic [NREQ-1:0]  win_onehot;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    // rel of non-owners never reaches this term, so rel=all-ones is harmless.
    assign exit_own   = bus.rel[own_idx] | ~bus.req[own_idx]
                      | (hold == CNT_W'(MAX_HOLD - 1));
    assign ptr_next   = (own_idx == IW'(NREQ - 1)) ? '0 : own_idx + 1'b1;
    assign win_onehot = NREQ'(1) << winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            own_idx <= '0;
            hold    <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            vout_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    vout_q <= 1'b0;
                    if (win_valid) begin
                        state   <= ST_OWN;
                        own_idx <= winner;
                        gnt_q   <= win_onehot;
                        hold    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_OWN: begin
                    if (exit_own) begin
                        state   <= ST_GAP;
                        ptr     <= ptr_next;
                        own_idx <= '0;
                        gnt_q   <= '0;
                        vout_q  <= 1'b0;
                    end else begin
                        hold   <= hold + 1'b1;
                        vout_q <= bus.vin[own_idx];
                    end
                end
                ST_GAP: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    vout_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    own_idx <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    vout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = own_idx;
    assign bus.busy  = busy_q;
    assign bus.vout  = vout_q;

endmodule

// File: tb/tb_pin_array_arb.sv
// Scoreboard bench for pin_array_arb against a cycle-level reference model.
module tb_pin_array_arb;

    localparam int N  = 4;
    localparam int MH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pin_array_arb_if #(.NREQ(N)) bus ();

    pin_array_arb #(
        .NREQ     (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int gnt;
        int owner;
        int busy;
        int vout;
    } obs_t;

    obs_t expq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference: phase 0 = free, 1 = someone holds the pin, 2 = gap cycle.
    int phase     = 0;
    int holder    = 0;
    int start_at  = 0;
    int held_for  = 0;
    int model_out = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] rl, input logic [N-1:0] v);
        obs_t e;
        bit found;
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        bus.rel = rl;
        bus.vin = v;
        if (r) begin
            phase = 0; holder = 0; start_at = 0; held_for = 0; model_out = 0;
        end else if (phase == 0) begin
            model_out = 0;
            if (rq != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && rq[(start_at + k) % N]) begin
                        found  = 1;
                        holder = (start_at + k) % N;
                    end
                end
                phase    = 1;
                held_for = 1;
            end
        end else if (phase == 1) begin
            if (rl[holder] || !rq[holder] || held_for == MH) begin
                phase     = 2;
                start_at  = (holder + 1) % N;
                model_out = 0;
            end else begin
                held_for++;
                model_out = int'(v[holder]);
            end
        end else begin
            phase     = 0;
            model_out = 0;
        end
        e.gnt   = (phase == 1) ? (1 << holder) : 0;
        e.owner = (phase == 1) ? holder : 0;
        e.busy  = (phase != 0) ? 1 : 0;
        e.vout  = model_out;
        expq.push_back(e);
    endtask

    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("gnt",   int'(bus.gnt),   e.gnt);
                check("owner", int'(bus.owner), e.owner);
                check("busy",  int'(bus.busy),  e.busy);
                check("vout",  int'(bus.vout),  e.vout);
            end
        end
    end

    initial begin
        logic [N-1:0] rq_r;
        logic [N-1:0] rl_r;
        bus.req = '0;
        bus.rel = '0;
        bus.vin = '0;

        // Reset state
        repeat (2) step(1, 4'b0000, 4'b0000, 4'b0000);

        // Lone requester, data path, voluntary release
        repeat (3) step(0, 4'b0001, 4'b0000, 4'b0001);
        step(0, 4'b0001, 4'b0001, 4'b0001);
        repeat (3) step(0, 4'b0000, 4'b0000, 4'b0000);

        // All requesting: full-length grants in round-robin order
        step(1, 4'b0000, 4'b0000, 4'b0000);
        repeat (5 * (MH + 2) + 4) step(0, 4'b1111, 4'b0000, 4'($urandom));
        repeat (3) step(0, 4'b0000, 4'b0000, 4'b0000);

        // Bring ptr to 3, then 3 and 0 request together
        step(1, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) step(0, 4'b0100, 4'b0000, 4'b0100);
        step(0, 4'b0100, 4'b0100, 4'b0100);
        repeat (4) step(0, 4'b1001, 4'b0000, 4'b1001);
        step(0, 4'b1001, 4'b1000, 4'b1001);
        repeat (4) step(0, 4'b1001, 4'b0000, 4'b1001);
        step(0, 4'b1001, 4'b0001, 4'b1001);
        repeat (3) step(0, 4'b0000, 4'b0000, 4'b0000);

        // Owner 2 drops req mid-hold while 0 and 1 queue up
        step(1, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) step(0, 4'b0100, 4'b0000, 4'b0100);
        repeat (4) step(0, 4'b0111, 4'b0000, 4'b0110);
        repeat (2 * (MH + 2) + 4) step(0, 4'b0011, 4'b0000, 4'($urandom));
        repeat (3) step(0, 4'b0000, 4'b0000, 4'b0000);

        // Reset while owner 1 drives vout high, req stays up
        step(1, 4'b0000, 4'b0000, 4'b0000);
        repeat (4) step(0, 4'b0010, 4'b0000, 4'b0010);
        step(1, 4'b0010, 4'b0000, 4'b0010);
        repeat (4) step(0, 4'b0010, 4'b0000, 4'b0010);

        // rel on every line: only the owner leaves
        step(1, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) step(0, 4'b0011, 4'b0000, 4'b0011);
        step(0, 4'b0011, 4'b1111, 4'b0011);
        repeat (5) step(0, 4'b0011, 4'b0000, 4'b0011);
        repeat (3) step(0, 4'b0000, 4'b0000, 4'b0000);

        // rel coincides with hold expiry
        step(1, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0001, 4'b0000, 4'b0001);
        repeat (MH - 1) step(0, 4'b0001, 4'b0000, 4'b0001);
        step(0, 4'b0001, 4'b0001, 4'b0001);
        repeat (4) step(0, 4'b0011, 4'b0000, 4'b0011);

        // Random traffic with persistent requests
        rq_r = '0;
        for (int c = 0; c < 3000; c++) begin
            rl_r = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) rq_r[b] = ~rq_r[b];
                if ($urandom_range(15) == 0) rl_r[b] = 1'b1;
            end
            step(($urandom_range(399) == 0), rq_r, rl_r, 4'($urandom));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
